// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a master and the apb_slave_mem block.
interface apb_slave_mem_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave backed by a DEPTH x 8-bit register memory with a fixed number
// of wait states per transfer.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in
// IDLE; the address/direction/data are latched there. In ACCESS the block
// counts down WAIT_STATES cycles and then raises pready for exactly one cycle
// while psel stays high; that is the only cycle where prdata and pslverr carry
// meaning. Dropping psel in any ACCESS cycle abandons the transfer. Writes
// commit on the edge that ends the pready cycle.
module apb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic             pclk_i,
  input  logic             preset_i,
  apb_slave_mem_if.slave   apb,
  output logic             state_o   // 0 = IDLE, 1 = ACCESS
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [3:0] WAIT_L  = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q,  wait_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] mem_q [DEPTH];

  logic setup_fire;
  logic access_live;
  logic done;
  logic addr_ok_q;
  logic in_addr_ok;
  logic commit;

  // Decode of the current cycle's role in the transfer.
  always_comb begin
    setup_fire  = (state_q == IDLE) && apb.psel && !apb.penable;
    access_live = (state_q == ACCESS) && apb.psel;
    done        = access_live && (wait_q == 4'd0);
    addr_ok_q   = ({1'b0, addr_q} < DEPTH_L);
    in_addr_ok  = ({1'b0, apb.paddr} < DEPTH_L);
    commit      = done && apb.penable && write_q && addr_ok_q;
  end

  // FSM state register.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a psel drop or the final access cycle both return to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup_fire) state_d = ACCESS;
      ACCESS:  if (!apb.psel || (wait_q == 4'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. pready is qualified by psel so an abandoned access cycle
  // never shows a completion, even when the counter has already expired.
  always_comb begin
    apb.pready  = done;
    apb.pslverr = done && !addr_ok_q;
    apb.prdata  = (done && !write_q) ? rdata_q : 8'h00;
    state_o     = state_q;
  end

  // Transfer context next-state: latch on setup, count down while waiting.
  // Bus inputs are deliberately not looked at outside the setup cycle.
  always_comb begin
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    if (setup_fire) begin
      wait_d  = WAIT_L;
      addr_d  = apb.paddr;
      wdata_d = apb.pwdata;
      write_d = apb.pwrite;
      rdata_d = in_addr_ok ? mem_q[apb.paddr[AW-1:0]] : 8'h00;
    end else if (access_live && (wait_q != 4'd0)) begin
      wait_d = wait_q - 4'd1;
    end
  end

  // Transfer context registers.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      wait_q  <= 4'd0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory array: cleared by reset, written only on a completed in-range write.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (commit) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with WAIT_STATES 1, 0, 3
// sharing clock and reset, each driven by its own bus bundle.
module tb_apb_slave_mem;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  // ---------------- per-instance bus signals ----------------
  logic [2:0] psel_v, penable_v, pwrite_v;
  logic [7:0] paddr_v  [3];
  logic [7:0] pwdata_v [3];
  logic [2:0] pready_v, pslverr_v, st_v;
  logic [7:0] prdata_v [3];

  apb_slave_mem_if if0 ();
  apb_slave_mem_if if1 ();
  apb_slave_mem_if if2 ();

  assign if0.psel = psel_v[0];  assign if0.penable = penable_v[0];
  assign if0.pwrite = pwrite_v[0]; assign if0.paddr = paddr_v[0];
  assign if0.pwdata = pwdata_v[0];
  assign if1.psel = psel_v[1];  assign if1.penable = penable_v[1];
  assign if1.pwrite = pwrite_v[1]; assign if1.paddr = paddr_v[1];
  assign if1.pwdata = pwdata_v[1];
  assign if2.psel = psel_v[2];  assign if2.penable = penable_v[2];
  assign if2.pwrite = pwrite_v[2]; assign if2.paddr = paddr_v[2];
  assign if2.pwdata = pwdata_v[2];

  assign pready_v[0] = if0.pready; assign pslverr_v[0] = if0.pslverr; assign prdata_v[0] = if0.prdata;
  assign pready_v[1] = if1.pready; assign pslverr_v[1] = if1.pslverr; assign prdata_v[1] = if1.prdata;
  assign pready_v[2] = if2.pready; assign pslverr_v[2] = if2.pslverr; assign prdata_v[2] = if2.prdata;

  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(1)) u_ws1 (
    .pclk_i(pclk), .preset_i(preset), .apb(if0.slave), .state_o(st_v[0]));
  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .pclk_i(pclk), .preset_i(preset), .apb(if1.slave), .state_o(st_v[1]));
  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .pclk_i(pclk), .preset_i(preset), .apb(if2.slave), .state_o(st_v[2]));

  // ---------------- scoreboard ----------------
  int         ws_of [3] = '{1, 0, 3};
  logic [7:0] mdl   [3][64];
  logic [7:0] exp_q [$];
  logic       err_q [$];
  int         total  = 0;
  int         passed = 0;
  int         failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 64; a++) mdl[k][a] = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs sampled 4 units later.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_all();
    psel_v = '0; penable_v = '0; pwrite_v = '0;
    for (int k = 0; k < 3; k++) begin
      paddr_v[k] = 8'h00; pwdata_v[k] = 8'h00;
    end
  endtask

  // One APB transfer on instance k. abort_at >= 0 drops psel in that access cycle.
  task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input int abort_at);
    int         ws;
    bit         in_rng;
    logic [7:0] e_rd;
    logic       e_err;
    ws     = ws_of[k];
    in_rng = (a < 8'd64);
    e_rd   = (!wr && in_rng) ? mdl[k][a[5:0]] : 8'h00;
    exp_q.push_back(e_rd);
    err_q.push_back(!in_rng);
    // setup phase
    tick();
    psel_v[k] = 1'b1; penable_v[k] = 1'b0; pwrite_v[k] = wr;
    paddr_v[k] = a; pwdata_v[k] = d;
    #4;
    check($sformatf("setup_state k%0d", k), st_v[k], 0);
    check($sformatf("setup_pready k%0d", k), pready_v[k], 0);
    // access phases; bus fields are scrambled since only latched values count
    for (int n = 0; n <= ws; n++) begin
      tick();
      psel_v[k] = 1'b1; penable_v[k] = 1'b1;
      pwrite_v[k] = 1'($urandom_range(0, 1));
      paddr_v[k]  = 8'($urandom_range(0, 255));
      pwdata_v[k] = 8'($urandom_range(0, 255));
      if (n == abort_at) begin
        psel_v[k] = 1'b0; penable_v[k] = 1'b0;
        #4;
        check($sformatf("abort_pready k%0d", k), pready_v[k], 0);
        check($sformatf("abort_pslverr k%0d", k), pslverr_v[k], 0);
        void'(exp_q.pop_front());
        void'(err_q.pop_front());
        return;
      end
      #4;
      check($sformatf("pready k%0d a%0h n%0d", k, a, n), pready_v[k], (n == ws));
      if (n == ws) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e_rd  = exp_q.pop_front();
          e_err = err_q.pop_front();
          check($sformatf("prdata k%0d a%0h", k, a), prdata_v[k], e_rd);
          check($sformatf("pslverr k%0d a%0h", k, a), pslverr_v[k], e_err);
        end
        if (wr && in_rng) mdl[k][a[5:0]] = d;
      end else begin
        check($sformatf("wait_prdata k%0d", k), prdata_v[k], 0);
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s pready k%0d", tag, k), pready_v[k], 0);
      check($sformatf("%s pslverr k%0d", tag, k), pslverr_v[k], 0);
      check($sformatf("%s prdata k%0d", tag, k), prdata_v[k], 0);
      check($sformatf("%s state k%0d", tag, k), st_v[k], 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    preset = 1'b1;
    idle_all();
    clear_model();
    tick(); tick();
    #4;
    check_quiet("in_reset");
    tick();
    preset = 1'b0;
    #4;
    check_quiet("after_reset");

    // V1: WAIT_STATES=1 write then read
    xfer(0, 1'b1, 8'h03, 8'h5A, -1);
    xfer(0, 1'b0, 8'h03, 8'h00, -1);

    // V2: WAIT_STATES=0 back-to-back write then read
    xfer(1, 1'b1, 8'h00, 8'h11, -1);
    xfer(1, 1'b0, 8'h00, 8'h00, -1);

    // V3: out-of-range write/read, then sweep all legal addresses
    xfer(0, 1'b1, 8'h40, 8'hFF, -1);
    xfer(0, 1'b0, 8'h40, 8'h00, -1);
    for (int a = 0; a < 64; a++) xfer(0, 1'b0, 8'(a), 8'h00, -1);

    // V4: WAIT_STATES=3 write abandoned in second access cycle
    xfer(2, 1'b1, 8'h09, 8'h33, -1);
    xfer(2, 1'b1, 8'h09, 8'hCC, 1);
    tick();
    psel_v[2] = 1'b0; penable_v[2] = 1'b0;
    #4;
    check("abort_state_idle", st_v[2], 0);
    xfer(2, 1'b0, 8'h09, 8'h00, -1);

    // V6: access strobe without setup is ignored
    tick();
    psel_v[1] = 1'b1; penable_v[1] = 1'b1; pwrite_v[1] = 1'b1;
    paddr_v[1] = 8'h00; pwdata_v[1] = 8'hEE;
    #4;
    check("v6_pready0", pready_v[1], 0);
    tick();
    #4;
    check("v6_pready1", pready_v[1], 0);
    check("v6_state", st_v[1], 0);
    tick();
    psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    xfer(1, 1'b0, 8'h00, 8'h00, -1);

    // Random mix across the instances
    for (int i = 0; i < 12; i++) begin
      xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 71)), 8'($urandom_range(0, 255)), -1);
    end

    // V5: reset during the wait of a write, after a committed write
    xfer(0, 1'b1, 8'h06, 8'h77, -1);
    tick();
    psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
    paddr_v[0] = 8'h05; pwdata_v[0] = 8'hAB;
    tick();
    penable_v[0] = 1'b1;
    preset = 1'b1;
    #4;
    check("v5_wait_pready", pready_v[0], 0);
    tick();
    preset = 1'b0;
    idle_all();
    clear_model();
    #4;
    check_quiet("v5_after_reset");
    xfer(0, 1'b0, 8'h05, 8'h00, -1);
    xfer(0, 1'b0, 8'h06, 8'h00, -1);

    tick();
    idle_all();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
